// File: rtl/fifo_to_gpio_pkg.sv
// Shared definitions for the EMIO GPIO <-> PL FIFO bridges.
// Both directions share one 40-bit EMIO bank layout. The writer constants are
// kept here so the two bridges agree on where the control bits live.
package fifo_to_gpio_pkg;

  localparam int GPIO_W = 40;

  // GPIO-to-FIFO writer, PS->PL control bits
  localparam int GPIO_WR_DATA_LSB  = 0;
  localparam int GPIO_WR_WRITE_BIT = 32;
  localparam int GPIO_WR_RST_BIT   = 33;

  // FIFO-to-GPIO reader, PS->PL control bits
  localparam int GPIO_CLR_BIT = 32;
  localparam int GPIO_REQ_BIT = 33;

  // FIFO-to-GPIO reader, PL->PS status bits
  localparam int GPIO_DATA_LSB  = 0;
  localparam int GPIO_ACK_BIT   = 32;
  localparam int GPIO_VALID_BIT = 33;
  localparam int GPIO_EMPTY_BIT = 34;
  localparam int GPIO_RSVD_BIT  = 35;
  localparam int GPIO_CNT_LSB   = 36;
  localparam int GPIO_CNT_W     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } rd_state_e;

endpackage

// File: rtl/fifo_to_gpio_sync.sv
// N-flop synchronizer with asynchronous reset, used for the PS request and
// clear bits arriving over EMIO.
// Ports:
//   clk - sampling clock
//   rst - asynchronous active-high reset, clears the whole chain
//   d   - asynchronous input bit
//   q   - synchronized output, STAGES clocks behind d
module gpio_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/fifo_to_gpio.sv
// Read-side bridge: pops one word from the PL FIFO per PS request and hands it
// to the PS over EMIO GPIO with a four-phase req/ack handshake.
// Ports:
//   clk         - PL clock, also the FIFO read clock
//   rst         - asynchronous active-high reset
//   emio_gpio_i - PS->PL: [33] rd_req, [32] clear
//   emio_gpio_o - PL->PS: [31:0] data, [32] ack, [33] valid, [34] empty,
//                 [35] 0, [39:36] read_count[3:0]
//   empty       - FIFO empty flag
//   din         - FIFO read data
//   rd_en       - FIFO read strobe, one-cycle pulse
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a request; pops if the FIFO has data
// WAIT  | read issued, counting down the FIFO read latency
// ACK   | ack held (valid set if a word was read) until req drops
module fifo_to_gpio
  import fifo_to_gpio_pkg::*;
#(
  parameter int READ_LATENCY = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [GPIO_W-1:0] emio_gpio_i,
  output logic [GPIO_W-1:0] emio_gpio_o,
  input  logic              empty,
  input  logic [31:0]       din,
  output logic              rd_en
);

  localparam logic [1:0] LAT_INIT = 2'(READ_LATENCY);

  logic       req_s;
  logic       clr_s;
  rd_state_e  state, state_nxt;
  logic [1:0] lat_cnt, lat_cnt_nxt;
  logic [31:0] data_q, data_nxt;
  logic       ack_q, ack_nxt;
  logic       valid_q, valid_nxt;
  logic       rd_en_q, rd_en_nxt;
  logic [7:0] read_count, read_count_nxt;

  gpio_sync #(.STAGES(SYNC_STAGES)) u_req_sync (
    .clk (clk),
    .rst (rst),
    .d   (emio_gpio_i[GPIO_REQ_BIT]),
    .q   (req_s)
  );

  gpio_sync #(.STAGES(SYNC_STAGES)) u_clr_sync (
    .clk (clk),
    .rst (rst),
    .d   (emio_gpio_i[GPIO_CLR_BIT]),
    .q   (clr_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      data_q     <= '0;
      ack_q      <= 1'b0;
      valid_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      read_count <= '0;
    end else begin
      state      <= state_nxt;
      lat_cnt    <= lat_cnt_nxt;
      data_q     <= data_nxt;
      ack_q      <= ack_nxt;
      valid_q    <= valid_nxt;
      rd_en_q    <= rd_en_nxt;
      read_count <= read_count_nxt;
    end
  end

  // rd_en is registered, so the FIFO sees it in the first WAIT cycle. With
  // READ_LATENCY=0 (FWFT) that same cycle has the word on din, which is why
  // the counter is loaded with READ_LATENCY and not READ_LATENCY-1.
  always_comb begin
    state_nxt      = state;
    lat_cnt_nxt    = lat_cnt;
    data_nxt       = data_q;
    ack_nxt        = ack_q;
    valid_nxt      = valid_q;
    rd_en_nxt      = 1'b0;
    read_count_nxt = read_count;

    if (clr_s) begin
      state_nxt      = IDLE;
      data_nxt       = '0;
      ack_nxt        = 1'b0;
      valid_nxt      = 1'b0;
      read_count_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_s) begin
            if (!empty) begin
              rd_en_nxt   = 1'b1;
              lat_cnt_nxt = LAT_INIT;
              state_nxt   = WAIT;
            end else begin
              // Nothing to read: acknowledge so the PS is not left hanging.
              ack_nxt   = 1'b1;
              valid_nxt = 1'b0;
              state_nxt = ACK;
            end
          end
        end
        WAIT: begin
          if (lat_cnt == 2'd0) begin
            data_nxt       = din;
            valid_nxt      = 1'b1;
            ack_nxt        = 1'b1;
            read_count_nxt = read_count + 8'd1;
            state_nxt      = ACK;
          end else begin
            lat_cnt_nxt = lat_cnt - 2'd1;
          end
        end
        ACK: begin
          // Leaving only on req low guarantees one pop per req high phase.
          if (!req_s) begin
            ack_nxt   = 1'b0;
            valid_nxt = 1'b0;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign rd_en = rd_en_q;

  always_comb begin
    emio_gpio_o                                 = '0;
    emio_gpio_o[GPIO_DATA_LSB +: 32]            = data_q;
    emio_gpio_o[GPIO_ACK_BIT]                   = ack_q;
    emio_gpio_o[GPIO_VALID_BIT]                 = valid_q;
    emio_gpio_o[GPIO_EMPTY_BIT]                 = empty;
    emio_gpio_o[GPIO_RSVD_BIT]                  = 1'b0;
    emio_gpio_o[GPIO_CNT_LSB +: GPIO_CNT_W]     = read_count[GPIO_CNT_W-1:0];
  end

  logic unused_bits;
  assign unused_bits = ^{emio_gpio_i[GPIO_W-1:GPIO_REQ_BIT+1],
                         emio_gpio_i[GPIO_CLR_BIT-1:0],
                         read_count[7:GPIO_CNT_W]};

endmodule

// File: tb/tb_fifo_to_gpio.sv
module tb_fifo_to_gpio;

  localparam int RL = 1;
  localparam int SS = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [39:0] emio_gpio_i;
  logic [39:0] gpio_o;
  logic        empty = 1'b1;
  logic [31:0] din = 32'h0;
  logic        rd_en;

  logic        req = 1'b0;
  logic        clr = 1'b0;
  logic [5:0]  junk_hi = 6'h0;
  logic [31:0] junk_lo = 32'h0;

  assign emio_gpio_i = {junk_hi, req, clr, junk_lo};

  always #5 clk = ~clk;

  fifo_to_gpio #(.READ_LATENCY(RL), .SYNC_STAGES(SS)) dut (
    .clk         (clk),
    .rst         (rst),
    .emio_gpio_i (emio_gpio_i),
    .emio_gpio_o (gpio_o),
    .empty       (empty),
    .din         (din),
    .rd_en       (rd_en)
  );

  wire        ack   = gpio_o[32];
  wire        valid = gpio_o[33];
  wire [31:0] data  = gpio_o[31:0];
  wire [3:0]  cnt   = gpio_o[39:36];

  // FIFO stub, standard (one-cycle) read latency
  logic [31:0] fifo_q[$];
  always @(posedge clk) begin
    if (rd_en && fifo_q.size() != 0) din <= fifo_q.pop_front();
    empty <= (fifo_q.size() == 0);
  end

  // Reference model: words in FIFO order, successful-read count, last word
  typedef struct {
    logic        valid;
    logic [31:0] data;
    logic [7:0]  cnt;
  } exp_t;

  logic [31:0] gold_q[$];
  exp_t        sb[$];
  int unsigned model_cnt = 0;
  logic [31:0] model_data = 32'h0;

  int checks = 0;
  int errors = 0;
  int rd_pulses = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic load_word(input logic [31:0] w);
    fifo_q.push_back(w);
    gold_q.push_back(w);
  endtask

  task automatic expect_req();
    if (gold_q.size() != 0) begin
      model_data = gold_q.pop_front();
      model_cnt  = (model_cnt + 1) % 256;
      sb.push_back('{1'b1, model_data, 8'(model_cnt)});
    end else begin
      sb.push_back('{1'b0, model_data, 8'(model_cnt)});
    end
  endtask

  task automatic handshake();
    int k;
    expect_req();
    req = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!ack && k < SS + 3);
    check("ack_rise_latency", 64'(ack), 64'd1);
    req = 1'b0;
    k = 0;
    do begin @(negedge clk); k++; end while (ack && k < SS + 1);
    check("ack_release_latency", 64'(ack), 64'd0);
  endtask

  task automatic clear_pulse();
    clr = 1'b1;
    repeat (SS + 2) @(negedge clk);
    check("clear_data", 64'(data), 64'd0);
    check("clear_ack_valid", 64'({ack, valid}), 64'd0);
    check("clear_count", 64'(cnt), 64'd0);
    clr = 1'b0;
    model_cnt  = 0;
    model_data = 32'h0;
    repeat (SS + 1) @(negedge clk);
  endtask

  // Monitor: compares each ack rising edge against the scoreboard
  logic prev_ack = 1'b0;
  logic prev_rd  = 1'b0;
  always @(negedge clk) begin
    if (rd_en) begin
      rd_pulses++;
      check("rd_en_single_cycle", 64'(prev_rd), 64'd0);
      check("rd_en_while_empty", 64'(empty), 64'd0);
    end
    if (ack && !prev_ack) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack actual=1 expected=0 t=%0t", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("ack_valid", 64'(valid), 64'(e.valid));
        check("ack_data", 64'(data), 64'(e.data));
        check("ack_count", 64'(cnt), 64'(e.cnt[3:0]));
        check("ack_reserved", 64'(gpio_o[35]), 64'd0);
      end
    end
    prev_ack = ack;
    prev_rd  = rd_en;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int k;
    logic [31:0] w;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'(gpio_o), 64'h04_0000_0000);
    check("reset_rd_en", 64'(rd_en), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single word
    load_word(32'hDEADBEEF);
    repeat (2) @(negedge clk);
    p0 = rd_pulses;
    handshake();
    check("single_pop_count", 64'(rd_pulses - p0), 64'd1);

    // Request against an empty FIFO
    p0 = rd_pulses;
    handshake();
    check("empty_no_pop", 64'(rd_pulses - p0), 64'd0);

    // Held request pops once
    clear_pulse();
    for (int i = 0; i < 3; i++) load_word($urandom);
    repeat (2) @(negedge clk);
    p0 = rd_pulses;
    expect_req();
    req = 1'b1;
    repeat (50) @(negedge clk);
    check("held_req_one_pop", 64'(rd_pulses - p0), 64'd1);
    check("held_req_ack", 64'(ack), 64'd1);
    req = 1'b0;
    repeat (SS + 1) @(negedge clk);
    check("held_req_release", 64'(ack), 64'd0);
    handshake();
    handshake();
    check("count_after_three", 64'(cnt), 64'(model_cnt % 16));

    // Twenty random handshakes, count wraps in the visible nibble
    clear_pulse();
    for (int i = 0; i < 20; i++) load_word($urandom);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      junk_hi = 6'($urandom);
      junk_lo = $urandom;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      handshake();
    end
    check("count_nibble_20", 64'(cnt), 64'(model_cnt % 16));
    check("fifo_drained", 64'(fifo_q.size()), 64'd0);

    // Clear during WAIT
    load_word($urandom);
    load_word($urandom);
    repeat (2) @(negedge clk);
    p0 = rd_pulses;
    req = 1'b1;
    @(negedge clk);
    clr = 1'b1;
    repeat (SS + 3) @(negedge clk);
    check("wait_clear_pop", 64'(rd_pulses - p0), 64'd1);
    check("wait_clear_ack_valid", 64'({ack, valid}), 64'd0);
    check("wait_clear_data", 64'(data), 64'd0);
    check("wait_clear_count", 64'(cnt), 64'd0);
    req = 1'b0;
    repeat (SS + 2) @(negedge clk);
    clr = 1'b0;
    repeat (SS + 2) @(negedge clk);
    void'(gold_q.pop_front());
    model_cnt  = 0;
    model_data = 32'h0;
    handshake();

    // Reset in the middle of ACK
    load_word($urandom);
    repeat (2) @(negedge clk);
    expect_req();
    req = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!ack && k < SS + 3);
    check("pre_reset_ack", 64'(ack), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("async_reset_outputs", 64'(gpio_o), 64'(40'(empty) << 34));
    check("async_reset_rd_en", 64'(rd_en), 64'd0);
    req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_cnt  = 0;
    model_data = 32'h0;
    load_word($urandom);
    p0 = rd_pulses;
    repeat (10) @(negedge clk);
    check("post_reset_idle_no_pop", 64'(rd_pulses - p0), 64'd0);
    handshake();

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_to_gpio.md
Name: fifo_to_gpio

Overview:
Read-side bridge from a PL FIFO to the PS over EMIO GPIO; the opposite direction to the GPIO-to-FIFO writer. The PS raises a request bit. The block pops one 32-bit word from the FIFO, presents it on the GPIO inputs with ack/valid flags, and completes a four-phase handshake. Sits between the time-tag result FIFO read port and the Zynq EMIO bank.

Parameters:
READ_LATENCY, 1, clk cycles from rd_en to valid dout on FIFO (1 = standard mode, 0 = FWFT); legal 0..3
SYNC_STAGES, 2, flops in the req/clear synchronizer chain; legal 2..3

Ports:
clk  input  1  single clock for PL logic and FIFO read port
rst  input  1  asynchronous active-high reset
emio_gpio_i  input  40  PS->PL bits: [33] rd_req, [32] clear, others ignored
emio_gpio_o  output  40  PL->PS bits: [31:0] data, [32] ack, [33] valid, [34] empty (live), [35] reserved 0, [39:36] read_count[3:0]
empty  input  1  FIFO empty flag
din  input  32  FIFO read data
rd_en  output  1  FIFO read strobe, single-cycle pulse

Behaviour:
- Reset (async, rst=1): state=IDLE, rd_en=0, data=0, ack=0, valid=0, read_count=0, sync chains=0; emio_gpio_o[34] still tracks empty combinationally.
- rd_req and clear pass through SYNC_STAGES flops; all logic below uses synced values (req_s, clr_s).
- IDLE: if req_s=1 and empty=0, then rd_en=1 for exactly one cycle and go to WAIT. If req_s=1 and empty=1, then ack=1, valid=0, data unchanged, go to ACK; no pop.
- WAIT: a down-counter is loaded with READ_LATENCY. When it reaches 0, latch data<=din, set valid=1 and ack=1, increment read_count (8-bit, wraps 255->0), go to ACK. With READ_LATENCY=0, din is sampled in the same cycle as rd_en.
- ACK: hold data/valid/ack. When req_s=0: ack=0, valid=0, go to IDLE. Data stays latched until the next successful read.
- Exactly one pop per req rising phase. req held high after ACK never causes a second pop. A new pop requires req to fall and then rise again.
- Worst-case latency from req_s high to ack: 1 (rd_en) + READ_LATENCY + 1 cycles.
- Clear (clr_s=1) has priority over every state. Go to IDLE, rd_en=0, ack=0, valid=0, data=0, read_count=0. If asserted while in WAIT, the already-popped word is discarded. While clr_s=1, no requests are serviced.
- rd_en is never asserted while empty=1. FIFO underflow is impossible by construction.
- emio_gpio_o[35] is tied 0. Bits [39:36] are read_count[3:0].

Decomposition:
- Shared package: GPIO bit-index constants (GPIO_DATA_LSB=0, GPIO_CLR_BIT=32, GPIO_REQ_BIT=33, GPIO_ACK_BIT=32, GPIO_VALID_BIT=33, GPIO_EMPTY_BIT=34, GPIO_CNT_LSB=36) and the state encoding (IDLE, WAIT, ACK). Define these alongside the writer's rst/write bit constants.
- One sub-module: gpio_sync, a parameterised N-flop synchronizer with async reset, instantiated for req and clear.

Test Plan:
- FIFO holds 0xDEADBEEF, READ_LATENCY=1. Raise req -> one rd_en pulse. ack=1, valid=1, data=0xDEADBEEF within SYNC_STAGES+3 cycles, read_count=1. Drop req -> ack=0 within SYNC_STAGES+1 cycles.
- FIFO empty, raise req -> no rd_en, ack=1, valid=0. Drop req -> ack=0, state IDLE.
- FIFO holds 3 words; hold req high for 50 cycles -> exactly one rd_en pulse. Then do 2 further full handshakes -> words returned in FIFO order, read_count=3.
- 20 handshakes against a 20-word FIFO -> bits [39:36] read 0x4 (20 mod 16), all data matches.
- Assert clear during WAIT -> ack/valid/data/read_count=0, state IDLE, no ack for that request. After clear drops, a new req pops the next word.
- Assert rst mid-ACK -> all outputs zero immediately (async, before next clk edge). After release, IDLE with req low produces no rd_en.
